// File: rtl/proj_seq_ctrl.sv
// proj_seq_ctrl -- read-level sequencing controller for the seeding pipeline.
//
// Walks one read through: k-mer buffer fill, per-base hashing with a running
// k-mer start index, pipeline drain, wait for the sorter, and one extender
// launch per minimiser slot.
//
// Ports
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   start              : begin one read (honoured only in IDLE)
//   in_valid/in_ready  : upstream base handshake; base_en = accepted base
//   idx_valid, idx     : k-mer signature valid for the sorter, k-mer start index
//   start_over         : end-of-read pulse to counter, buffer and sorter
//   sort_valid         : sorter has its minimiser indices ready
//   ext_go, ext_sel    : launch the extender on sorted slot ext_sel
//   ext_done, fm_wait  : extender finished slot / FM memory busy
//   busy, done, err    : not-idle, read-complete pulse, sort-timeout pulse
module proj_seq_ctrl #(
    parameter int READ_LEN  = 150,
    parameter int KMER_LEN  = 16,
    parameter int NUM_MINS  = 4,
    parameter int DRAIN_CYC = 3,
    parameter int SORT_TMO  = 255,
    localparam int IDX_W    = $clog2(READ_LEN),
    localparam int SEL_W    = (NUM_MINS > 1) ? $clog2(NUM_MINS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             base_en,
    output logic             idx_valid,
    output logic [IDX_W-1:0] idx,
    output logic             start_over,
    input  logic             sort_valid,
    output logic             ext_go,
    output logic [SEL_W-1:0] ext_sel,
    input  logic             ext_done,
    input  logic             fm_wait,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int FILL_W = $clog2(KMER_LEN) + 1;
    localparam int DRN_W  = $clog2(DRAIN_CYC) + 1;
    localparam int TMO_W  = $clog2(SORT_TMO) + 1;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((KMER_LEN > 1) ? (KMER_LEN - 2) : 0);
    localparam logic [IDX_W-1:0]  HASH_LAST = IDX_W'(READ_LEN - KMER_LEN);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DRAIN_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SORT_TMO - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_MINS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SORTW = 3'd4,
        ST_EXT   = 3'd5,
        ST_EXTW  = 3'd6,
        ST_FIN   = 3'd7
    } state_t;

    state_t            state_r, state_s;
    logic [FILL_W-1:0] fill_cnt_r, fill_cnt_s;
    logic [IDX_W-1:0]  hash_cnt_r, hash_cnt_s;
    logic [DRN_W-1:0]  drain_cnt_r, drain_cnt_s;
    logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
    logic [SEL_W-1:0]  ext_sel_r, ext_sel_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic              in_ready_r, in_ready_s;
    logic              idx_valid_r, idx_valid_s;
    logic              start_over_r, start_over_s;
    logic              ext_go_r, ext_go_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              accept_s;

    // in_ready_r mirrors "state is FILL or HASH", so this is the real handshake.
    assign accept_s = in_ready_r & in_valid;

    assign in_ready   = in_ready_r;
    assign base_en    = accept_s;
    assign idx_valid  = idx_valid_r;
    assign idx        = idx_r;
    assign start_over = start_over_r;
    assign ext_go     = ext_go_r;
    assign ext_sel    = ext_sel_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

    // Next-state and next-output decode; every registered output is computed here.
    always_comb begin
        state_s      = state_r;
        fill_cnt_s   = fill_cnt_r;
        hash_cnt_s   = hash_cnt_r;
        drain_cnt_s  = drain_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;
        ext_sel_s    = ext_sel_r;
        idx_s        = idx_r;
        idx_valid_s  = 1'b0;
        start_over_s = 1'b0;
        ext_go_s     = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    fill_cnt_s = '0;
                    hash_cnt_s = '0;
                    idx_s      = '0;
                    ext_sel_s  = '0;
                    // A one-base k-mer is complete on its first base: no fill phase.
                    state_s    = (KMER_LEN > 1) ? ST_FILL : ST_HASH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    if (fill_cnt_r == FILL_LAST) begin
                        fill_cnt_s = '0;
                        state_s    = ST_HASH;
                    end else begin
                        fill_cnt_s = fill_cnt_r + FILL_W'(1);
                    end
                end else begin
                    fill_cnt_s = fill_cnt_r;
                end
            end
            ST_HASH: begin
                if (accept_s) begin
                    // The signature reflects the base just shifted in, so it is
                    // presented the cycle after acceptance together with its index.
                    idx_valid_s = 1'b1;
                    idx_s       = hash_cnt_r;
                    if (hash_cnt_r == HASH_LAST) begin
                        start_over_s = 1'b1;
                        drain_cnt_s  = '0;
                        state_s      = ST_DRAIN;
                    end else begin
                        hash_cnt_s = hash_cnt_r + IDX_W'(1);
                    end
                end else begin
                    hash_cnt_s = hash_cnt_r;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRN_LAST) begin
                    tmo_cnt_s = '0;
                    state_s   = ST_SORTW;
                end else begin
                    drain_cnt_s = drain_cnt_r + DRN_W'(1);
                end
            end
            ST_SORTW: begin
                if (sort_valid) begin
                    state_s = ST_EXT;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            ST_EXT: begin
                if (!fm_wait) begin
                    ext_go_s = 1'b1;
                    state_s  = ST_EXTW;
                end else begin
                    state_s = ST_EXT;
                end
            end
            ST_EXTW: begin
                if (ext_done) begin
                    if (ext_sel_r == SEL_LAST) begin
                        state_s = ST_FIN;
                    end else begin
                        ext_sel_s = ext_sel_r + SEL_W'(1);
                        state_s   = ST_EXT;
                    end
                end else begin
                    state_s = ST_EXTW;
                end
            end
            ST_FIN: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        in_ready_s = (state_s == ST_FILL) || (state_s == ST_HASH);
        busy_s     = (state_s != ST_IDLE);
    end

    // State, counters and registered outputs; reset abandons any read silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            fill_cnt_r   <= '0;
            hash_cnt_r   <= '0;
            drain_cnt_r  <= '0;
            tmo_cnt_r    <= '0;
            ext_sel_r    <= '0;
            idx_r        <= '0;
            in_ready_r   <= 1'b0;
            idx_valid_r  <= 1'b0;
            start_over_r <= 1'b0;
            ext_go_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            fill_cnt_r   <= fill_cnt_s;
            hash_cnt_r   <= hash_cnt_s;
            drain_cnt_r  <= drain_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
            ext_sel_r    <= ext_sel_s;
            idx_r        <= idx_s;
            in_ready_r   <= in_ready_s;
            idx_valid_r  <= idx_valid_s;
            start_over_r <= start_over_s;
            ext_go_r     <= ext_go_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
        end
    end

endmodule
